// File: rtl/inst_loader.sv
// Program loader: turns a count-prefixed byte stream into big-endian 32-bit
// instruction-memory writes at consecutive addresses, holding the CPU meanwhile.
module inst_loader #(
   parameter int ADDR_W    = 8,
   parameter int ADDR_STEP = 4,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk_Loader,
   input  logic              rst_Loader,
   input  logic              start,
   input  logic [7:0]        byte_data,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic [7:0]        words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_DATA,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] L_STEP = ADDR_W'(ADDR_STEP);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_n;
   logic [1:0] r_bcnt;
   logic [7:0] r_wcnt;
   logic       w_xfer;

   assign w_xfer       = byte_valid & byte_ready;
   assign words_loaded = r_wcnt;

   always_ff @(posedge clk_Loader) begin
      if (rst_Loader) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   // Strobes depend only on r_state; inputs steer only the next state.
   always_comb begin
      w_next     = r_state;
      byte_ready = 1'b0;
      im_we      = 1'b0;
      cpu_hold   = 1'b1;
      load_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            cpu_hold = 1'b0;
            if (start) w_next = S_COUNT;
         end
         S_COUNT: begin
            byte_ready = 1'b1;
            if (byte_valid) w_next = (byte_data == 8'd0) ? S_DONE : S_DATA;
         end
         S_DATA: begin
            byte_ready = 1'b1;
            if (byte_valid && r_bcnt == 2'd3) w_next = S_WRITE;
         end
         S_WRITE: begin
            im_we  = 1'b1;
            w_next = (r_wcnt + 8'd1 == r_n) ? S_DONE : S_DATA;
         end
         S_DONE: begin
            load_done = 1'b1;
            w_next    = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_Loader) begin
      if (rst_Loader) begin
         r_n      <= 8'd0;
         r_bcnt   <= 2'd0;
         r_wcnt   <= 8'd0;
         im_addr  <= L_BASE;
         im_wdata <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_wcnt  <= 8'd0;
                  r_bcnt  <= 2'd0;
                  im_addr <= L_BASE;
               end
            end
            S_COUNT: begin
               if (w_xfer) r_n <= byte_data;
            end
            S_DATA: begin
               if (w_xfer) begin
                  im_wdata <= {im_wdata[23:0], byte_data};
                  r_bcnt   <= r_bcnt + 2'd1;
               end
            end
            S_WRITE: begin
               // Address wraps modulo 2^ADDR_W by truncation.
               r_wcnt  <= r_wcnt + 8'd1;
               r_bcnt  <= 2'd0;
               im_addr <= im_addr + L_STEP;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: byte-stream driver, write scoreboard, per-scenario tasks.
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst, start, bv;
   logic [7:0]  bd;
   logic        br, we, hold, done;
   logic [7:0]  addr;
   logic [31:0] wd;
   logic [7:0]  wl;

   always #5 clk = ~clk;

   inst_loader dut (
      .clk_Loader  (clk),
      .rst_Loader  (rst),
      .start       (start),
      .byte_data   (bd),
      .byte_valid  (bv),
      .byte_ready  (br),
      .im_we       (we),
      .im_addr     (addr),
      .im_wdata    (wd),
      .cpu_hold    (hold),
      .load_done   (done),
      .words_loaded(wl)
   );

   typedef struct packed {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_q[$];
   logic [7:0]  tx_q[$];
   logic [31:0] wbuf[$];
   wr_t         mon_e;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (mon_en && we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h", addr, wd);
         end else begin
            mon_e = exp_q.pop_front();
            if (addr !== mon_e.a || wd !== mon_e.d) begin
               errors++;
               $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                        addr, wd, mon_e.a, mon_e.d);
            end
         end
      end
   end

   task automatic build();
      logic [31:0] w;
      tx_q.delete();
      tx_q.push_back(8'(wbuf.size()));
      for (int k = 0; k < wbuf.size(); k++) begin
         w = wbuf[k];
         tx_q.push_back(w[31:24]);
         tx_q.push_back(w[23:16]);
         tx_q.push_back(w[15:8]);
         tx_q.push_back(w[7:0]);
         exp_q.push_back({8'((k * 4) % 256), w});
      end
   endtask

   task automatic run_load(input int gap, input int budget, input int stop_x,
                           output int done_c, output int we_c, output int we_first,
                           output int hold_first, output int hold_last, output int hold_n,
                           output logic post_hold, output logic post_ready, output int xfers);
      bit fin;
      fin = 1'b0;
      done_c = -1; we_c = 0; we_first = -1; hold_first = -1; hold_last = -1;
      hold_n = 0; xfers = 0; post_hold = 1'bx; post_ready = 1'bx;
      @(posedge clk); #1;
      start = 1'b1; bv = 1'b0;
      @(negedge clk);
      if (hold) begin hold_first = 0; hold_last = 0; hold_n++; end
      for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (tx_q.size() > 0 && $urandom_range(99) >= gap) begin
            bv = 1'b1; bd = tx_q[0];
         end else begin
            bv = 1'b0;
         end
         @(negedge clk);
         if (hold) begin
            if (hold_first < 0) hold_first = cyc;
            hold_last = cyc;
            hold_n++;
         end
         if (we) begin
            if (we_first < 0) we_first = cyc;
            we_c++;
         end
         if (bv && br) begin
            void'(tx_q.pop_front());
            xfers++;
            if (xfers == stop_x) fin = 1'b1;
         end
         if (done) begin done_c = cyc; fin = 1'b1; end
      end
      if (done_c >= 0) begin
         @(posedge clk); #1;
         bv = 1'b0;
         @(negedge clk);
         post_hold = hold; post_ready = br;
      end
   endtask

   int   dc, wc, wf, hf, hl, hn, xf;
   logic ph, pr;

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bv = 1'b1; bd = 8'hA5;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({br, we, hold, done} !== 4'b0000 || wl !== 8'd0 ||
             addr !== 8'h00 || wd !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d br=%b we=%b hold=%b done=%b wl=%h addr=%h wd=%h required all zero",
                     i, br, we, hold, done, wl, addr, wd);
         end
      end
      bv = 1'b0;
   endtask

   task automatic test_single();
      wbuf = '{32'h12345678};
      build();
      run_load(0, 50, -1, dc, wc, wf, hf, hl, hn, ph, pr, xf);
      checks++; if (dc !== 7) begin errors++; $display("FAIL single_done_cycle got %0d need 7", dc); end
      checks++; if (wc !== 1 || wf !== 6) begin errors++; $display("FAIL single_we got count=%0d first=%0d need 1/6", wc, wf); end
      checks++; if (hf !== 1 || hl !== 7 || hn !== 7) begin errors++; $display("FAIL single_hold got %0d..%0d n=%0d need 1..7 n=7", hf, hl, hn); end
      checks++; if (ph !== 1'b0 || pr !== 1'b0) begin errors++; $display("FAIL single_post_idle hold=%b ready=%b need 0/0", ph, pr); end
      checks++; if (wl !== 8'd1) begin errors++; $display("FAIL single_words got %0d need 1", wl); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing_writes got %0d left need 0", exp_q.size()); end
   endtask

   task automatic test_gaps();
      wbuf = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
      build();
      run_load(40, 400, -1, dc, wc, wf, hf, hl, hn, ph, pr, xf);
      checks++; if (dc < 17) begin errors++; $display("FAIL gaps_done_cycle got %0d need >=17", dc); end
      checks++; if (wc !== 3 || wl !== 8'd3) begin errors++; $display("FAIL gaps_count we=%0d wl=%0d need 3/3", wc, wl); end
      checks++; if (hn !== hl - hf + 1 || ph !== 1'b0) begin errors++; $display("FAIL gaps_hold n=%0d span=%0d..%0d post=%b", hn, hf, hl, ph); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gaps_missing_writes got %0d left need 0", exp_q.size()); end
   endtask

   task automatic test_zero();
      wbuf.delete();
      build();
      run_load(0, 20, -1, dc, wc, wf, hf, hl, hn, ph, pr, xf);
      checks++; if (dc !== 2) begin errors++; $display("FAIL zero_done_cycle got %0d need 2", dc); end
      checks++; if (wc !== 0 || wl !== 8'd0) begin errors++; $display("FAIL zero_count we=%0d wl=%0d need 0/0", wc, wl); end
      checks++; if (hf !== 1 || hl !== 2 || ph !== 1'b0) begin errors++; $display("FAIL zero_hold got %0d..%0d post=%b need 1..2 post=0", hf, hl, ph); end
   endtask

   task automatic test_wrap();
      wbuf.delete();
      for (int k = 0; k < 65; k++) wbuf.push_back(32'hC0DE0000 | 32'(k));
      build();
      run_load(0, 2000, -1, dc, wc, wf, hf, hl, hn, ph, pr, xf);
      checks++; if (dc !== 2 + 5 * 65) begin errors++; $display("FAIL wrap_done_cycle got %0d need %0d", dc, 2 + 5 * 65); end
      checks++; if (wc !== 65 || wl !== 8'd65) begin errors++; $display("FAIL wrap_count we=%0d wl=%0d need 65/65", wc, wl); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing_writes got %0d left need 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      wbuf = '{32'h11112222, 32'h33334444};
      build();
      run_load(0, 100, 7, dc, wc, wf, hf, hl, hn, ph, pr, xf);
      checks++; if (xf !== 7 || wc !== 1) begin errors++; $display("FAIL midrst_progress xfers=%0d we=%0d need 7/1", xf, wc); end
      @(posedge clk); #1;
      rst = 1'b1; bv = 1'b1; bd = 8'h55;
      @(negedge clk);
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL midrst_we_in_reset got %b need 0", we); end
      @(posedge clk); #1;
      rst = 1'b0; bv = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checks++;
      if (hold !== 1'b0 || br !== 1'b0 || we !== 1'b0 || wl !== 8'd0) begin
         errors++;
         $display("FAIL midrst_idle hold=%b ready=%b we=%b wl=%0d need 0/0/0/0", hold, br, we, wl);
      end
      repeat (4) @(posedge clk);
      wbuf = '{32'hDEADBEEF};
      build();
      run_load(0, 50, -1, dc, wc, wf, hf, hl, hn, ph, pr, xf);
      checks++; if (dc !== 7 || wc !== 1 || wl !== 8'd1) begin errors++; $display("FAIL midrst_reload done=%0d we=%0d wl=%0d need 7/1/1", dc, wc, wl); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_missing_writes got %0d left need 0", exp_q.size()); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; bv = 1'b0; bd = 8'h00;
      mon_en = 1'b1;
      test_reset();
      test_single();
      test_gaps();
      test_zero();
      test_wrap();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader on the initiator side of the instruction-memory write port. Receives a byte stream (valid/ready) from a host or UART front end, assembles big-endian 32-bit instructions, writes them into instruction memory at consecutive word addresses, and holds the CPU pipeline while loading. It is the writer side for the instruction memory that the CPU's PC/fetch path reads; it sits between the host link and the `InstMemory` write port, alongside `CPUControlRType`.

## Interface

Parameters:
- `ADDR_W`, 8: instruction address width; matches the 8-bit PC.
- `ADDR_STEP`, 4: address increment per word; PC is byte-addressed.
- `BASE_ADDR`, 0: address of the first loaded word.

Ports:
- `clk_Loader`  in  1  system clock, the same net as `clk_CPU`; all state updates on the rising edge.
- `rst_Loader`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `byte_data`  in  8  stream byte.
- `byte_valid`  in  1  `byte_data` is valid this cycle.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `im_we`  out  1  instruction-memory write strobe.
- `im_addr`  out  ADDR_W  write address.
- `im_wdata`  out  32  write data.
- `cpu_hold`  out  1  stalls the PC and pipeline registers while high.
- `load_done`  out  1  one-cycle pulse at the end of a load.
- `words_loaded`  out  8  count of words written in the current or last load.

## Operation

- Stream format: one count byte N (0..255), then 4·N data bytes, most significant byte first.
- A byte transfers when `byte_valid && byte_ready`. Bytes offered when `byte_ready`=0 are not consumed; the host holds them.
- State machine: IDLE, COUNT, DATA, WRITE, DONE.
  - IDLE: `byte_ready`=0, `cpu_hold`=0. If `start`=1, go to COUNT and clear `words_loaded`, the byte counter, and the address.
  - COUNT: `byte_ready`=1. On transfer, latch N. If N=0 go to DONE, otherwise go to DATA.
  - DATA: `byte_ready`=1. On each transfer, `word <= {word[23:0], byte_data}` and the byte counter increments. On the 4th byte go to WRITE.
  - WRITE: `byte_ready`=0 and `im_we`=1 for exactly one cycle.
    - `im_addr` = BASE_ADDR + k·ADDR_STEP, modulo 2^ADDR_W; `im_wdata` = the assembled word.
    - `words_loaded` increments, the byte counter clears, and the address advances.
    - If `words_loaded`+1 == N go to DONE, otherwise go to DATA.
  - DONE: `load_done`=1 and `cpu_hold`=1 for one cycle, then IDLE.
- `cpu_hold`=1 in COUNT, DATA, WRITE and DONE.
- `start` is ignored outside IDLE.
- Address wrap: the address wraps silently modulo 2^ADDR_W. No error is flagged.
- `im_we`, `byte_ready`, `cpu_hold` and `load_done` are decoded from the registered state only; there are no combinational paths from inputs to outputs.
- `im_wdata` and `im_addr` are registers; their values outside WRITE are don't-care.
- Reset has priority over all other events. A reset mid-load returns to IDLE without a write in the reset cycle; partially assembled words are discarded.

## Timing

- Reset values: state IDLE, `byte_ready`=0, `im_we`=0, `im_addr`=BASE_ADDR, `im_wdata`=0, `cpu_hold`=0, `load_done`=0, `words_loaded`=0.
- With `start` at cycle 0 and `byte_valid` held high:
  - COUNT in cycle 1.
  - Word k bytes in cycles 2+5k through 5+5k.
  - `im_we` in cycle 6+5k.
  - DONE in cycle 2+5N; IDLE and `cpu_hold`=0 in cycle 3+5N.
- With N=0: DONE in cycle 2, IDLE in cycle 3, no `im_we`.
- Throughput is 5 cycles per word at full rate. Stalls on `byte_valid` stretch DATA or COUNT with no other effect.

## Test plan

- Reset, then idle for 5 cycles: all outputs at their reset values; `cpu_hold`=0; `byte_ready`=0 even if `byte_valid`=1.
- `start`, then stream 01,12,34,56,78 at full rate: `im_we` in cycle 6 only, `im_addr`=0x00, `im_wdata`=0x12345678. `load_done` in cycle 7, `words_loaded`=1, `cpu_hold` high for cycles 1–7.
- N=3 with random `byte_valid` gaps; words 0xAAAA0001, 0xBBBB0002, 0xCCCC0003: three writes at addresses 0x00, 0x04, 0x08 with matching data; the byte ordering is preserved across gaps.
- N=0: `load_done` in cycle 2, `im_we` never asserted, `words_loaded`=0.
- Wrap with N=65 and BASE_ADDR=0: word 64 is written at `im_addr`=0x00; all 65 strobes are present; `words_loaded`=65.
- Assert `rst_Loader` after 2 data bytes of word 1:
  - No `im_we` occurs in or after the reset cycle.
  - The loader returns to IDLE and `cpu_hold`=0 on the next cycle.
  - A subsequent `start` with N=1 writes cleanly to address 0x00.
